// File: rtl/int2flt_core_if.sv
// Handshake and data bundle for the int16 -> IEEE-half converter.
// Master drives start/int_i; slave returns busy/done/flt_o.
interface int2flt_core_if;
  logic        start;
  logic [15:0] int_i;
  logic        busy;
  logic        done;
  logic [15:0] flt_o;

  modport master (output start, int_i, input busy, done, flt_o);
  modport slave  (input start, int_i, output busy, done, flt_o);
endinterface

// File: rtl/int2flt_core.sv
// Serial int16 -> IEEE half converter, one normalising shift per leading zero; latency s+2 (1 for zero).
// start is ignored while busy; flt_o holds the last result until the next conversion loads it.
module int2flt_core #(
  parameter int BIAS = 15
) (
  input  logic          clk,
  input  logic          reset,
  int2flt_core_if.slave bus
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t      state, state_n;
  logic        sign, sign_n;
  logic [15:0] mag, mag_n;
  logic [4:0]  exp_r, exp_n;
  logic [15:0] flt, flt_n;
  logic [15:0] abs_in;
  logic        rnd_inc;
  logic [10:0] m_sum;

  // 0x8000 negates to itself, which is exactly the magnitude wanted.
  assign abs_in  = bus.int_i[15] ? (~bus.int_i + 16'd1) : bus.int_i;
  assign rnd_inc = mag[4] & ((|mag[3:0]) | mag[5]);
  assign m_sum   = {1'b0, mag[14:5]} + {10'd0, rnd_inc};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sign  <= 1'b0;
      mag   <= 16'd0;
      exp_r <= 5'd0;
      flt   <= 16'd0;
    end else begin
      state <= state_n;
      sign  <= sign_n;
      mag   <= mag_n;
      exp_r <= exp_n;
      flt   <= flt_n;
    end
  end

  always_comb begin
    state_n = state;
    sign_n  = sign;
    mag_n   = mag;
    exp_n   = exp_r;
    flt_n   = flt;
    case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (bus.start) begin
          sign_n = bus.int_i[15];
          mag_n  = abs_in;
          exp_n  = 5'(BIAS + 15);
          // Operands already normalised skip straight to rounding so latency stays s+2.
          if (abs_in == 16'd0) begin
            state_n = DONE;
            flt_n   = 16'd0;
          end else if (abs_in[15]) begin
            state_n = ROUND;
          end else begin
            state_n = NORM;
          end
        end
      end
      NORM: begin
        if (mag[15]) begin
          state_n = ROUND;
        end else begin
          mag_n = {mag[14:0], 1'b0};
          exp_n = exp_r - 5'd1;
          // Leave as soon as the shift brings the leading one into bit 15.
          if (mag[14]) state_n = ROUND;
        end
      end
      ROUND: begin
        // A carry out of m leaves m_sum[9:0] already zero; only the exponent moves.
        if (m_sum[10]) exp_n = exp_r + 5'd1;
        flt_n   = {sign, (m_sum[10] ? exp_r + 5'd1 : exp_r), m_sum[9:0]};
        state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy  = (state == NORM) || (state == ROUND);
  assign bus.done  = (state == DONE);
  assign bus.flt_o = flt;

endmodule

// File: tb/tb_int2flt_core.sv
// Bench for int2flt_core: table of operands with known half results and latencies,
// plus hand sequences for busy-ignore, back-to-back accept and reset abort.
module tb_int2flt_core;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic busy_seen = 1'b0;

  int2flt_core_if bus ();

  int2flt_core #(.BIAS(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] flt;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [15:0] op;
    logic [15:0] flt;
    int          lat;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  // Output side of the scoreboard: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.busy) busy_seen = 1'b1;
    if (bus.done) begin
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("flt_o", {16'd0, bus.flt_o}, {16'd0, e.flt});
        chk("latency", cyc - e.acc + 1, e.lat);
      end else begin
        chk("spurious_done", {31'd0, bus.done}, 32'd0);
      end
    end
  end

  task automatic drive(input logic [15:0] op, input logic [15:0] flt, input int lat);
    bus.start = 1'b1;
    bus.int_i = op;
    busy_seen = 1'b0;
    sb.push_back('{flt: flt, lat: lat, acc: cyc + 1});
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      chk({name, "_timeout"}, sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic run_one(input logic [15:0] op, input logic [15:0] flt, input int lat);
    for (int i = 0; i < 40 && bus.busy; i++) @(negedge clk);
    @(negedge clk);
    drive(op, flt, lat);
    @(negedge clk);
    bus.start = 1'b0;
    bus.int_i = 16'($urandom);
    #1;
    drain("run");
    chk("busy_seen", {31'd0, busy_seen}, {31'd0, (lat > 1)});
  endtask

  initial begin
    vecs[0]  = '{op: 16'h0001, flt: 16'h3C00, lat: 17};
    vecs[1]  = '{op: 16'hFFFF, flt: 16'hBC00, lat: 17};
    vecs[2]  = '{op: 16'h7FFF, flt: 16'h7800, lat: 3};
    vecs[3]  = '{op: 16'h8000, flt: 16'hF800, lat: 2};
    vecs[4]  = '{op: 16'h0801, flt: 16'h6800, lat: 6};
    vecs[5]  = '{op: 16'h0803, flt: 16'h6802, lat: 6};
    vecs[6]  = '{op: 16'h0802, flt: 16'h6801, lat: 6};
    vecs[7]  = '{op: 16'h0000, flt: 16'h0000, lat: 1};
    vecs[8]  = '{op: 16'h0400, flt: 16'h6400, lat: 7};
    vecs[9]  = '{op: 16'h0064, flt: 16'h5640, lat: 11};
    vecs[10] = '{op: 16'hFF9C, flt: 16'hD640, lat: 11};
    vecs[11] = '{op: 16'h1234, flt: 16'h6C8D, lat: 5};

    bus.start = 1'b0;
    bus.int_i = 16'h0000;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_flt", {16'd0, bus.flt_o}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run_one(vecs[i].op, vecs[i].flt, vecs[i].lat);

    // Start pulses and operand churn while busy must not disturb the conversion.
    @(negedge clk);
    drive(16'h0001, 16'h3C00, 17);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.start = i[0];
      bus.int_i = 16'($urandom);
    end
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    drain("busy_ignore");
    repeat (3) @(negedge clk);

    // Start held in the DONE cycle is accepted with no IDLE gap.
    drive(16'h0400, 16'h6400, 7);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 40 && !bus.done; i++) @(negedge clk);
    #1;
    chk("b2b_done_seen", {31'd0, bus.done}, 32'd1);
    drive(16'h8000, 16'hF800, 2);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
    drain("b2b");

    // Reset in the middle of normalisation throws the conversion away.
    @(negedge clk);
    bus.start = 1'b1;
    bus.int_i = 16'h0001;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy_before_rst", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_flt", {16'd0, bus.flt_o}, 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    run_one(16'h0400, 16'h6400, 7);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
